// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared types and constants for the SPI config writer.
// FSM states, frame layout and the downstream register address map.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam int FRAME_W = 16;
  localparam logic WR_BIT = 1'b1;

  localparam logic [6:0] OUT_7_0  = 7'h00;
  localparam logic [6:0] OUT_15_8 = 7'h01;
  localparam logic [6:0] PWM_7_0  = 7'h02;
  localparam logic [6:0] PWM_15_8 = 7'h03;
  localparam logic [6:0] DUTY     = 7'h04;

  function automatic logic [FRAME_W-1:0] mk_frame(
    input logic [6:0] addr,
    input logic [7:0] data
  );
    return {WR_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_arbiter.sv
// spi_cfg_arbiter: 2-way round-robin arbiter, combinational grant.
// Ports: clk, rst_n, en (grant allowed), req[1:0] in; gnt[1:0] one-hot out.
module spi_cfg_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // prio_q set: requester 1 wins a tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt = prio_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/spi_cfg_controller.sv
// spi_cfg_controller: arbitrates two writers, sends 16-bit mode-0 SPI frames.
// Ports: clk, rst_n, req/addr/data x2 in; gnt, busy, done, SCLK, COPI, nCS out.
module spi_cfg_controller
  import spi_cfg_pkg::*;
#(
  parameter int HALF_DIV = 4,
  parameter int GAP_CYC  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [6:0] req_addr0,
  input  logic [6:0] req_addr1,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam logic [7:0] HD_LAST  = 8'(HALF_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_e state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic sclk_q, sclk_d;
  logic copi_q, copi_d;
  logic ncs_q, ncs_d;
  logic done_q, done_d;
  // holds off grants until the first edge after reset release
  logic run_q;
  logic arb_en;
  logic [FRAME_W-1:0] frame_w;

  assign arb_en = (state_q == ST_IDLE) && run_q;

  spi_cfg_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  assign frame_w = gnt[1] ? mk_frame(req_addr1, req_data1)
                          : mk_frame(req_addr0, req_data0);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (|gnt) begin
          state_d = ST_SETUP;
          sr_d    = frame_w;
          copi_d  = frame_w[FRAME_W-1];
          ncs_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (div_q == HD_LAST) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_q == HD_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            // falling edge: present next bit
            sclk_d = 1'b0;
            sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
            copi_d = sr_q[FRAME_W-2];
          end else if (bit_q == 4'd15) begin
            state_d = ST_HOLD;
            bit_d   = '0;
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (div_q == HD_LAST) begin
          state_d = ST_GAP;
          div_d   = '0;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (div_q == GAP_LAST) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
      run_q   <= 1'b1;
    end
  end

  assign busy = (state_q != ST_IDLE) || (|gnt);
  assign done = done_q;
  assign SCLK = sclk_q;
  assign COPI = copi_q;
  assign nCS  = ncs_q;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// tb_spi_cfg_controller: directed bench with a downstream SPI receiver model.
// Drives a HALF_DIV=4 instance and a HALF_DIV=2 instance.
module tb_spi_cfg_controller;

  localparam int GAP = 8;
  localparam int LAT_A = 1 + 4 * 34;
  localparam int LAT_B = 1 + 2 * 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req, req_b;
  logic [6:0] addr0, addr1, addr0_b, addr1_b;
  logic [7:0] data0, data1, data0_b, data1_b;
  logic [1:0] gnt, gnt_b;
  logic busy, done, sclk, copi, ncs;
  logic busy_b, done_b, sclk_b, copi_b, ncs_b;

  spi_cfg_controller #(.HALF_DIV(4), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_addr0(addr0), .req_addr1(addr1),
    .req_data0(data0), .req_data1(data1),
    .gnt(gnt), .busy(busy), .done(done),
    .SCLK(sclk), .COPI(copi), .nCS(ncs)
  );

  spi_cfg_controller #(.HALF_DIV(2), .GAP_CYC(GAP)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .req_addr0(addr0_b), .req_addr1(addr1_b),
    .req_data0(data0_b), .req_data1(data1_b),
    .gnt(gnt_b), .busy(busy_b), .done(done_b),
    .SCLK(sclk_b), .COPI(copi_b), .nCS(ncs_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // downstream receiver model, one channel per instance
  logic [1:0] sclk_v, copi_v, ncs_v, dn_v;
  assign sclk_v = {sclk_b, sclk};
  assign copi_v = {copi_b, copi};
  assign ncs_v  = {ncs_b, ncs};
  assign dn_v   = {done_b, done};

  logic [1:0] p_sclk = 2'b00;
  logic [1:0] p_copi = 2'b00;
  logic [1:0] p_ncs  = 2'b11;
  logic [15:0] sh [2];
  logic [15:0] last_frame [2];
  int bits [2];
  int last_bits [2];
  int hi_run [2];
  int last_gap [2];
  int viol [2];
  int done_cnt [2];
  logic [7:0] regs [5];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sh[i] = '0; last_frame[i] = '0; bits[i] = 0;
      last_bits[i] = 0; hi_run[i] = 0; last_gap[i] = 0;
      viol[i] = 0; done_cnt[i] = 0;
    end
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dn_v[i]) done_cnt[i]++;
      if (!ncs_v[i] && !p_ncs[i] && copi_v[i] != p_copi[i]
          && !(p_sclk[i] && !sclk_v[i]))
        viol[i]++;
      if (!ncs_v[i] && p_ncs[i]) begin
        last_gap[i] = hi_run[i];
        hi_run[i] = 0;
        bits[i] = 0;
        sh[i] = '0;
      end
      if (!ncs_v[i] && sclk_v[i] && !p_sclk[i]) begin
        sh[i] = {sh[i][14:0], copi_v[i]};
        bits[i]++;
      end
      if (ncs_v[i]) hi_run[i]++;
      if (ncs_v[i] && !p_ncs[i]) begin
        last_frame[i] = sh[i];
        last_bits[i] = bits[i];
        if (i == 0 && bits[i] == 16 && sh[i][15]
            && sh[i][14:8] <= 7'd4)
          regs[int'(sh[i][14:8])] = sh[i][7:0];
      end
    end
    p_sclk = sclk_v;
    p_copi = copi_v;
    p_ncs  = ncs_v;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input int sel,
                          output logic [1:0] g,
                          output int t);
    g = 2'b00;
    t = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      g = (sel != 0) ? gnt_b : gnt;
      if (g != 2'b00) begin
        t = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL gnt_timeout: dut %0d no grant in 300 cycles", sel);
  endtask

  task automatic wait_done(input int sel, output int t);
    t = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (((sel != 0) ? done_b : done) == 1'b1) begin
        t = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: dut %0d no done in 400 cycles", sel);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [6:0]  a0;
    logic [7:0]  d0;
    logic [6:0]  a1;
    logic [7:0]  d1;
    logic [1:0]  gnt;
    logic [15:0] frame;
  } vec_t;

  vec_t vt [5];
  logic [1:0] g;
  int tg, td, dc, found;
  logic [1:0] rr_exp [3];
  logic [15:0] rr_frm [3];

  initial begin
    vt[0] = '{2'b01, 7'h04, 8'h80, 7'h00, 8'h00, 2'b01, 16'h8480};
    vt[1] = '{2'b10, 7'h00, 8'h00, 7'h7F, 8'hFF, 2'b10, 16'hFFFF};
    vt[2] = '{2'b01, 7'h00, 8'hA5, 7'h00, 8'h00, 2'b01, 16'h80A5};
    vt[3] = '{2'b10, 7'h00, 8'h00, 7'h02, 8'h3C, 2'b10, 16'h823C};
    vt[4] = '{2'b11, 7'h01, 8'h11, 7'h03, 8'h33, 2'b01, 16'h8111};
    rr_exp = '{2'b01, 2'b10, 2'b01};
    rr_frm = '{16'h8201, 16'h8302, 16'h8201};

    req = 2'b11; addr0 = 7'h04; data0 = 8'h80;
    addr1 = 7'h04; data1 = 8'h80;
    req_b = 2'b00; addr0_b = '0; data0_b = '0;
    addr1_b = '0; data1_b = '0;

    // reset state with requests pending
    repeat (3) @(negedge clk);
    check("rst_ncs", ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_copi", copi, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    #1;
    check("rel_gnt", gnt, 0);
    req = 2'b00;

    // table-driven single frames
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      addr0 = vt[i].a0; data0 = vt[i].d0;
      addr1 = vt[i].a1; data1 = vt[i].d1;
      req = vt[i].req;
      wait_gnt(0, g, tg);
      check($sformatf("v%0d_gnt", i), g, vt[i].gnt);
      check($sformatf("v%0d_busy", i), busy, 1);
      @(posedge clk);
      #1;
      req = 2'b00;
      wait_done(0, td);
      check($sformatf("v%0d_lat", i), td - tg, LAT_A);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_frame", i), last_frame[0], vt[i].frame);
      check($sformatf("v%0d_bits", i), last_bits[0], 16);
    end
    check("copi_viol", viol[0], 0);
    check("reg0", regs[0], 8'hA5);
    check("reg1", regs[1], 8'h11);
    check("reg2", regs[2], 8'h3C);
    check("reg3", regs[3], 8'h00);
    check("reg4", regs[4], 8'h80);

    // round-robin with both held, pointer fresh from reset
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    addr0 = 7'h02; data0 = 8'h01;
    addr1 = 7'h03; data1 = 8'h02;
    req = 2'b11;
    dc = done_cnt[0];
    for (int k = 0; k < 3; k++) begin
      wait_gnt(0, g, tg);
      check($sformatf("rr%0d_gnt", k), g, rr_exp[k]);
      if (k == 2) begin
        @(posedge clk);
        #1;
        req = 2'b00;
      end
      wait_done(0, td);
      repeat (2) @(negedge clk);
      check($sformatf("rr%0d_frame", k), last_frame[0], rr_frm[k]);
    end
    check("rr_dones", done_cnt[0] - dc, 3);
    check("rr_reg2", regs[2], 8'h01);
    check("rr_reg3", regs[3], 8'h02);

    // reset during bit 9 of a duty write
    addr0 = 7'h04; data0 = 8'h55;
    req = 2'b01;
    wait_gnt(0, g, tg);
    @(posedge clk);
    #1;
    req = 2'b00;
    found = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bits[0] == 9) begin
        found = 1;
        break;
      end
    end
    check("mid_found", found, 1);
    dc = done_cnt[0];
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_ncs", ncs, 1);
    check("mid_sclk", sclk, 0);
    check("mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_nodone", done_cnt[0] - dc, 0);
    check("mid_bits", last_bits[0], 9);
    check("mid_reg4", regs[4], 8'h80);

    // HALF_DIV=2 back-to-back frames
    addr0_b = 7'h01; data0_b = 8'h5A;
    req_b = 2'b01;
    wait_gnt(1, g, tg);
    check("b0_gnt", g, 2'b01);
    wait_done(1, td);
    check("b0_lat", td - tg, LAT_B);
    repeat (2) @(negedge clk);
    check("b0_bits", last_bits[1], 16);
    check("b0_frame", last_frame[1], 16'h815A);
    wait_gnt(1, g, tg);
    check("b1_gnt", g, 2'b01);
    @(posedge clk);
    #1;
    req_b = 2'b00;
    repeat (2) @(negedge clk);
    check("b_gap", last_gap[1] >= GAP, 1);
    wait_done(1, td);
    check("b1_lat", td - tg, LAT_B);
    repeat (2) @(negedge clk);
    check("b1_bits", last_bits[1], 16);
    check("b_viol", viol[1], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
